// File: rtl/perm_engine.sv
// perm_engine: programmable, pipelined bit-permutation engine.
// A WIDTH-bit word is permuted through a run-time loadable 1-based index
// table, either forward (gather: out[i] = in[tab[i]]) or inverse
// (scatter: out[tab[i]] |= in[i]). One output register, valid/ready stream.
// Optional build macro: PERM_CHECK_EN enables the registered bijection
// check on tab_ok; without it tab_ok is tied high.

module perm_engine #(
    parameter  int WIDTH = 32,
    localparam int IDXW  = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_addr,
    input  logic [IDXW-1:0] cfg_data,
    output logic            cfg_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inv,
    input  logic [1:WIDTH]  data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:WIDTH]  data_out,
    output logic            tab_ok
);

    // Largest legal table index, sized to the index width.
    localparam logic [IDXW-1:0] LP_MAX = IDXW'(WIDTH);

    // Reject illegal widths at elaboration rather than building nonsense.
    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("perm_engine: WIDTH must be in 2..64");
    end

    logic [IDXW-1:0] r_tab     [1:WIDTH];
    logic [IDXW-1:0] w_tab_nxt [1:WIDTH];
    logic            w_cfg_ok;
    logic            w_accept;
    logic [1:WIDTH]  w_fwd;
    logic [1:WIDTH]  w_inv;
    logic [1:WIDTH]  w_perm;
    logic            r_out_valid;
    logic [1:WIDTH]  r_data_out;
    logic            r_cfg_err;

    // A write is legal only when both the address and the source index
    // name a real bit position; index 0 and anything above WIDTH are holes.
    assign w_cfg_ok = (cfg_addr != '0) && (cfg_addr <= LP_MAX) &&
                      (cfg_data != '0) && (cfg_data <= LP_MAX);

    // Single output register: we can take a word whenever the register is
    // empty or is being drained this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Next-state table: the addressed entry is replaced by a legal write,
    // every other entry holds.
    always_comb begin
        for (int i = 1; i <= WIDTH; i++) begin
            w_tab_nxt[i] = r_tab[i];
            if (cfg_we && w_cfg_ok && (cfg_addr == IDXW'(i))) begin
                w_tab_nxt[i] = cfg_data;
            end
        end
    end

    // Table storage; reset returns it to the identity permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= WIDTH; i++) begin
                r_tab[i] <= IDXW'(i);
            end
        end else begin
            for (int i = 1; i <= WIDTH; i++) begin
                r_tab[i] <= w_tab_nxt[i];
            end
        end
    end

    // Both permutation directions from the current (pre-write) table.
    // Inverse mode ORs colliding sources; unreached destinations stay 0.
    always_comb begin
        w_fwd = '0;
        w_inv = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            for (int j = 1; j <= WIDTH; j++) begin
                if (r_tab[i] == IDXW'(j)) begin
                    w_fwd[i] = w_fwd[i] | data_in[j];
                    w_inv[j] = w_inv[j] | data_in[i];
                end
            end
        end
    end

    assign w_perm = in_inv ? w_inv : w_fwd;

    // Output register: load on accept, drop valid once drained, and hold
    // data stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_data_out  <= w_perm;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // One-cycle error pulse for each rejected configuration write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign cfg_err   = r_cfg_err;

`ifdef PERM_CHECK_EN
    logic [1:WIDTH] w_hit;
    logic           r_tab_ok;

    // Mark every index reached by the next table; with WIDTH entries,
    // full coverage means each index appears exactly once.
    always_comb begin
        w_hit = '0;
        for (int j = 1; j <= WIDTH; j++) begin
            for (int i = 1; i <= WIDTH; i++) begin
                if (w_tab_nxt[i] == IDXW'(j)) begin
                    w_hit[j] = 1'b1;
                end
            end
        end
    end

    // Bijection flag tracks the table it describes, edge for edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tab_ok <= 1'b1;
        end else begin
            r_tab_ok <= &w_hit;
        end
    end

    assign tab_ok = r_tab_ok;
`else
    assign tab_ok = 1'b1;
`endif

endmodule

// File: tb/tb_perm_engine.sv
// Testbench for perm_engine (WIDTH=32). A monitor keeps a reference table
// and pushes the expected word whenever an input handshake completes; it
// pops and compares whenever an output handshake completes. Scenario tasks
// add their own direct checks of handshake, error and table-status outputs.

module tb_perm_engine;

    localparam int WIDTH = 32;
    localparam int IDXW  = 6;

`ifdef PERM_CHECK_EN
    localparam logic EXP_DUP_OK = 1'b0;
`else
    localparam logic EXP_DUP_OK = 1'b1;
`endif

    logic            clk;
    logic            rst_n;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_addr;
    logic [IDXW-1:0] cfg_data;
    logic            cfg_err;
    logic            in_valid;
    logic            in_ready;
    logic            in_inv;
    logic [1:WIDTH]  data_in;
    logic            out_valid;
    logic            out_ready;
    logic [1:WIDTH]  data_out;
    logic            tab_ok;

    int nVec  = 0;
    int nMis  = 0;
    int popCount = 0;
    int mTab [1:WIDTH];
    logic [1:WIDTH] expQ [$];

    perm_engine #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .tab_ok    (tab_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference permutation computed from the bench's own table copy.
    function automatic logic [1:WIDTH] modelPerm(input logic [1:WIDTH] d, input logic inv);
        logic [1:WIDTH] r;
        r = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (!inv) r[i] = d[mTab[i]];
            else      r[mTab[i]] = r[mTab[i]] | d[i];
        end
        return r;
    endfunction

    // Scoreboard monitor, sampling mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            for (int i = 1; i <= WIDTH; i++) mTab[i] = i;
        end else begin
            if (out_valid && out_ready) begin
                nVec++;
                if (expQ.size() == 0) begin
                    nMis++;
                    $display("[TB] FAIL scoreboard_extra: got %h required no output", data_out);
                end else begin
                    logic [1:WIDTH] e;
                    e = expQ.pop_front();
                    popCount++;
                    if (data_out !== e) begin
                        nMis++;
                        $display("[TB] FAIL scoreboard_data: got %h required %h", data_out, e);
                    end
                end
            end
            if (in_valid && in_ready) expQ.push_back(modelPerm(data_in, in_inv));
            if (cfg_we && cfg_addr >= 1 && cfg_addr <= WIDTH &&
                cfg_data >= 1 && cfg_data <= WIDTH)
                mTab[cfg_addr] = int'(cfg_data);
        end
    end

    // Present one word until the DUT accepts it (bounded).
    task automatic driveWord(input logic [1:WIDTH] d, input logic inv);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        data_in  = d;
        in_inv   = inv;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        nVec++;
        if (!acc) begin
            nMis++;
            $display("[TB] FAIL accept_timeout: got no accept required accept");
        end
    endtask

    // One-cycle configuration write.
    task automatic writeCfg(input logic [IDXW-1:0] a, input logic [IDXW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_inv = 1'b0; data_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
        nVec++; if (in_ready !== 1'b1) begin nMis++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
        nVec++; if (data_out !== '0) begin nMis++; $display("[TB] FAIL reset_data_out: got %h required 0", data_out); end
        nVec++; if (cfg_err !== 1'b0) begin nMis++; $display("[TB] FAIL reset_cfg_err: got %b required 0", cfg_err); end
        nVec++; if (tab_ok !== 1'b1) begin nMis++; $display("[TB] FAIL reset_tab_ok: got %b required 1", tab_ok); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        driveWord(32'hDEADBEEF, 1'b0);
        nVec++; if (out_valid !== 1'b1) begin nMis++; $display("[TB] FAIL ident_valid: got %b required 1", out_valid); end
        nVec++; if (data_out !== 32'hDEADBEEF) begin nMis++; $display("[TB] FAIL ident_data: got %h required deadbeef", data_out); end
        @(posedge clk);
        #1;
        nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL ident_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_des_p();
        int p [1:32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                         2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
        for (int i = 1; i <= WIDTH; i++) writeCfg(IDXW'(i), IDXW'(p[i]));
        @(posedge clk);
        #1;
        nVec++; if (tab_ok !== 1'b1) begin nMis++; $display("[TB] FAIL desp_tab_ok: got %b required 1", tab_ok); end
        driveWord(32'h00010000, 1'b0);
        nVec++; if (data_out !== 32'h80000000) begin nMis++; $display("[TB] FAIL desp_fwd: got %h required 80000000", data_out); end
        driveWord(32'h80000000, 1'b1);
        nVec++; if (data_out !== 32'h00010000) begin nMis++; $display("[TB] FAIL desp_inv: got %h required 00010000", data_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [1:WIDTH] words [8];
        logic [1:WIDTH] held;
        logic           haveHeld;
        logic           acc;
        int             k;
        int             stallCycles;
        int             basePops;
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        k = 0; stallCycles = 0; haveHeld = 1'b0; held = '0;
        basePops = popCount;
        for (int c = 0; c < 60 && (k < 8 || out_valid); c++) begin
            in_valid  = (k < 8);
            data_in   = (k < 8) ? words[k] : '0;
            in_inv    = k[0];
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                stallCycles++;
                nVec++;
                if (in_ready !== 1'b0) begin nMis++; $display("[TB] FAIL stall_in_ready: got %b required 0", in_ready); end
                if (haveHeld) begin
                    nVec++;
                    if (data_out !== held) begin nMis++; $display("[TB] FAIL stall_hold: got %h required %h", data_out, held); end
                end else begin
                    held = data_out;
                    haveHeld = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        nVec++; if (stallCycles !== 3) begin nMis++; $display("[TB] FAIL stall_cycles: got %0d required 3", stallCycles); end
        nVec++; if (popCount - basePops !== 8) begin nMis++; $display("[TB] FAIL stall_count: got %0d required 8", popCount - basePops); end
    endtask

    task automatic test_cfg_err();
        writeCfg(6'd5, 6'd0);
        nVec++; if (cfg_err !== 1'b1) begin nMis++; $display("[TB] FAIL err_data0: got %b required 1", cfg_err); end
        @(posedge clk);
        #1;
        nVec++; if (cfg_err !== 1'b0) begin nMis++; $display("[TB] FAIL err_pulse_len: got %b required 0", cfg_err); end
        writeCfg(6'd33, 6'd1);
        nVec++; if (cfg_err !== 1'b1) begin nMis++; $display("[TB] FAIL err_addr33: got %b required 1", cfg_err); end
        writeCfg(6'd0, 6'd3);
        nVec++; if (cfg_err !== 1'b1) begin nMis++; $display("[TB] FAIL err_back2back: got %b required 1", cfg_err); end
        @(posedge clk);
        #1;
        nVec++; if (cfg_err !== 1'b0) begin nMis++; $display("[TB] FAIL err_clear: got %b required 0", cfg_err); end
        driveWord(32'h00010000, 1'b0);
        nVec++; if (data_out !== 32'h80000000) begin nMis++; $display("[TB] FAIL err_table_kept: got %h required 80000000", data_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dup();
        for (int i = 1; i <= WIDTH; i++) writeCfg(IDXW'(i), IDXW'(i));
        writeCfg(6'd2, 6'd1);
        @(posedge clk);
        #1;
        nVec++; if (tab_ok !== EXP_DUP_OK) begin nMis++; $display("[TB] FAIL dup_tab_ok: got %b required %b", tab_ok, EXP_DUP_OK); end
        driveWord(32'hC0000000, 1'b1);
        nVec++; if (data_out !== 32'h80000000) begin nMis++; $display("[TB] FAIL dup_inv_or: got %h required 80000000", data_out); end
        writeCfg(6'd2, 6'd2);
        @(posedge clk);
        #1;
        nVec++; if (tab_ok !== 1'b1) begin nMis++; $display("[TB] FAIL dup_restore: got %b required 1", tab_ok); end
    endtask

    task automatic test_coincident();
        in_valid = 1'b1; data_in = 32'h40000000; in_inv = 1'b0;
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = 6'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        nVec++; if (data_out !== 32'h40000000) begin nMis++; $display("[TB] FAIL coinc_old: got %h required 40000000", data_out); end
        driveWord(32'h40000000, 1'b0);
        nVec++; if (data_out !== 32'hC0000000) begin nMis++; $display("[TB] FAIL coinc_new: got %h required c0000000", data_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        driveWord(32'h12345678, 1'b0);
        nVec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nMis++; $display("[TB] FAIL mid_stall: got v=%b r=%b required v=1 r=0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL mid_async_valid: got %b required 0", out_valid); end
        nVec++; if (data_out !== '0 || in_ready !== 1'b1) begin nMis++; $display("[TB] FAIL mid_async_out: got %h/%b required 0/1", data_out, in_ready); end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        driveWord(32'h40000000, 1'b0);
        nVec++; if (data_out !== 32'h40000000) begin nMis++; $display("[TB] FAIL mid_identity: got %h required 40000000", data_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_drain();
        repeat (2) @(posedge clk);
        #1;
        nVec++; if (expQ.size() !== 0) begin nMis++; $display("[TB] FAIL drain_queue: got %0d pending required 0", expQ.size()); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_des_p();
        test_stall();
        test_cfg_err();
        test_dup();
        test_coincident();
        test_reset_mid();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/perm_engine.md
# perm_engine

Programmable, pipelined bit-permutation engine; the parametrised successor to the fixed DES P-box. Permutes a WIDTH-bit word through a run-time loadable 1-based index table, in forward (gather) or inverse (scatter) mode. Uses a valid/ready stream handshake. Sits between the S-box stage and the round XOR, and can be reprogrammed for the IP, IP⁻¹ and P tables without new RTL.

## Interface
- WIDTH, 32, data word width in bits; legal range 2..64.
- IDXW, $clog2(WIDTH+1), table entry width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDXW  entry to write, 1..WIDTH.
- cfg_data  in  IDXW  source index, 1..WIDTH.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word.
- in_inv  in  1  mode for this word: 0 forward, 1 inverse.
- data_in  in  [1:WIDTH]  input word; bit 1 is the MSB.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- data_out  out  [1:WIDTH]  permuted word.
- tab_ok  out  1  table is a bijection (see Configuration).

## Operation
- Table: WIDTH entries tab[1..WIDTH], each IDXW bits. Reset value is identity, tab[i]=i.
- Forward mode: data_out[i] = data_in[tab[i]] for all i.
- Inverse mode: data_out[tab[i]] = data_in[i].
  - Destination bits hit by several entries take the OR of their sources.
  - Destination bits hit by no entry are 0.
- Config write: accepted when cfg_we=1, 1≤cfg_addr≤WIDTH and 1≤cfg_data≤WIDTH. Otherwise the write is rejected, the table is unchanged, and cfg_err=1 on the next cycle.
- Handshake: a transfer occurs on a rising edge with valid&ready. in_ready = !out_valid | out_ready (single output register, full throughput).
- While out_valid=1 and out_ready=0: data_out is held stable and in_ready=0.
- Config write and accepted input in the same cycle: the input word uses the pre-write table. The new entry applies from the next accepted word.
- Words already in the output register are never altered by config writes.

## Timing
- Reset values: out_valid=0, data_out=0, cfg_err=0, in_ready=1, tab_ok=1, table=identity.
- Latency: 1 cycle. A word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- out_valid falls after the edge where out_ready=1 and no new word is accepted.
- cfg_err is registered and lasts exactly 1 cycle per rejected write. Back-to-back rejected writes give consecutive pulses.
- Table write is visible to the datapath one edge after cfg_we.
- Reset asserted mid-stream: the in-flight word is discarded, outputs take reset values immediately (asynchronous), and the table returns to identity.

## Configuration
- PERM_CHECK_EN defined: tab_ok is registered every cycle. It is 1 only if every index 1..WIDTH appears exactly once in the table, and it updates one edge after any table write.
- PERM_CHECK_EN undefined: tab_ok is tied to 1 and no coverage logic is built. Inverse-mode duplicate/hole behaviour is unchanged.

## Test plan
- After reset, forward, in_data=32'hDEADBEEF, out_ready=1 → data_out=32'hDEADBEEF (identity) one cycle later. Before reset release: out_valid=0, in_ready=1.
- Load DES P table (tab[1]=16, tab[9]=1, …). Forward, data_in=32'h00010000 (bit 16) → data_out=32'h80000000. Inverse, data_in=32'h80000000 → data_out=32'h00010000.
- Stream 8 random words with out_ready low for cycles 3–5 → data_out held, in_ready=0 during the stall, all 8 outputs correct and in order, no loss or duplication.
- cfg_we with cfg_addr=5, cfg_data=0 → cfg_err pulses 1 cycle; a subsequent forward word still matches the old table. A write with cfg_addr=WIDTH+1 gives the same result.
- With PERM_CHECK_EN, set tab[2]=1 on identity → tab_ok=0. Inverse, data_in=32'hC0000000 → data_out=32'h80000000 (OR, bit 2 hole = 0). Restore tab[2]=2 → tab_ok=1.
- Config write coincident with an accepted word → that word uses the old table; the next word uses the new one. Assert rst_n mid-stall → out_valid=0 at once and the table reverts to identity.
